// File: rtl/frame_stack_if.sv
// Bundle of request/response signals between a caller (register-file side)
// and the frame_stack call-frame store. clk/reset stay outside the bundle.
//
// Request semantics: push and pop are level requests sampled on the rising
// clock edge, and only while busy is low. A request seen while busy is high
// is ignored and leaves no trace. When both are high, push wins and the pop
// is dropped silently. An accepted request raises busy on the same edge.
// The caller holds a request until that edge and must then wait for busy to
// fall before it issues the next one. A restore completes with a single-cycle
// restore strobe, and frameOut is valid during that strobe.
interface frame_stack_if #(
   parameter int DEPTH = 16,
   parameter int WORDS = 15
);
   localparam int FW = 16 * WORDS;
   localparam int DW = $clog2(DEPTH) + 1;

   logic          push;
   logic          pop;
   logic [FW-1:0] frameIn;
   logic [FW-1:0] frameOut;
   logic          restore;
   logic          busy;
   logic          full;
   logic          empty;
   logic [DW-1:0] depth;
   logic          overflow;
   logic          underflow;
   // FSM state exposed for observation: 0 idle, 1 save, 2 load, 3 restore
   logic [1:0]    dbg_state;

   modport master (
      output push, pop, frameIn,
      input  frameOut, restore, busy, full, empty, depth,
             overflow, underflow, dbg_state
   );

   modport slave (
      input  push, pop, frameIn,
      output frameOut, restore, busy, full, empty, depth,
             overflow, underflow, dbg_state
   );
endinterface

// File: rtl/frame_stack.sv
// Call-frame stack for the 16-bit register file context (regs 0-14).
// A frame is moved one 16-bit word per cycle through a single-port style
// memory. A save takes 15 cycles. A restore takes 17: 15 reads, one cycle
// of read latency, and one cycle for the restore strobe.
module frame_stack #(
   parameter int DEPTH = 16,
   parameter int WORDS = 15
) (
   input  logic          clk,
   input  logic          reset,
   frame_stack_if.slave  bus
);
   localparam int FW    = 16 * WORDS;
   localparam int DW    = $clog2(DEPTH) + 1;
   localparam int MEM_N = DEPTH * WORDS;
   localparam int AW    = $clog2(MEM_N + 1);
   localparam int BW    = $clog2(WORDS + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SAVE    = 2'd1;
   localparam logic [1:0] S_LOAD    = 2'd2;
   localparam logic [1:0] S_RESTORE = 2'd3;

   localparam logic [DW-1:0] DEPTH_MAX  = DW'(DEPTH);
   localparam logic [AW-1:0] FRAME_STEP = AW'(WORDS);
   localparam logic [BW-1:0] LAST_BEAT  = BW'(WORDS - 1);
   // In LOAD the counter runs one step past the last read, so that the
   // final word can be captured from the memory output register.
   localparam logic [BW-1:0] CAP_DONE   = BW'(WORDS);

   logic [1:0]    r_state;
   logic [BW-1:0] r_beat;
   logic [AW-1:0] r_base;
   logic [DW-1:0] r_depth;
   logic          r_overflow;
   logic          r_underflow;
   logic [FW-1:0] r_shift;
   logic [FW-1:0] r_frame_out;
   logic [15:0]   r_rd_data;
   logic [15:0]   r_mem [MEM_N];

   logic          w_idle;
   logic          w_full;
   logic          w_empty;
   logic          w_push_ok;
   logic          w_pop_ok;
   logic          w_push_rej;
   logic          w_pop_rej;
   logic          w_save_last;
   logic          w_load_last;
   logic          w_load_read;
   logic          w_load_cap;
   logic [AW-1:0] w_addr;
   logic [BW-1:0] w_cap_idx;

   assign w_idle  = (r_state == S_IDLE);
   assign w_full  = (r_depth == DEPTH_MAX);
   assign w_empty = (r_depth == '0);

   // Push has priority; a pop that arrives with a push is dropped silently.
   assign w_push_ok  = w_idle &  bus.push & ~w_full;
   assign w_push_rej = w_idle &  bus.push &  w_full;
   assign w_pop_ok   = w_idle & ~bus.push &  bus.pop & ~w_empty;
   assign w_pop_rej  = w_idle & ~bus.push &  bus.pop &  w_empty;

   assign w_save_last = (r_state == S_SAVE) && (r_beat == LAST_BEAT);
   assign w_load_last = (r_state == S_LOAD) && (r_beat == CAP_DONE);
   assign w_load_read = (r_state == S_LOAD) && (r_beat <= LAST_BEAT);
   assign w_load_cap  = (r_state == S_LOAD) && (r_beat != '0);

   // base already points at the frame being saved (push) or at the frame
   // being restored (pop, base was lowered on the accept edge).
   assign w_addr    = r_base + AW'(r_beat);
   assign w_cap_idx = r_beat - BW'(1);

   // Sequence IDLE -> SAVE -> IDLE or IDLE -> LOAD -> RESTORE -> IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_push_ok)
                  r_state <= S_SAVE;
               else if (w_pop_ok)
                  r_state <= S_LOAD;
            end
            S_SAVE: begin
               if (w_save_last)
                  r_state <= S_IDLE;
            end
            S_LOAD: begin
               if (w_load_last)
                  r_state <= S_RESTORE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Beat counter: cleared on accept, advanced once per SAVE/LOAD cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_beat <= '0;
      end else if (w_push_ok || w_pop_ok) begin
         r_beat <= '0;
      end else if ((r_state == S_SAVE) || (r_state == S_LOAD)) begin
         r_beat <= r_beat + BW'(1);
      end
   end

   // Committed depth and base address; a save counts only once written
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_depth <= '0;
         r_base  <= '0;
      end else if (w_save_last) begin
         r_depth <= r_depth + DW'(1);
         r_base  <= r_base + FRAME_STEP;
      end else if (w_pop_ok) begin
         r_depth <= r_depth - DW'(1);
         r_base  <= r_base - FRAME_STEP;
      end
   end

   // Sticky error flags for rejected requests, cleared only by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push_rej)
            r_overflow <= 1'b1;
         if (w_pop_rej)
            r_underflow <= 1'b1;
      end
   end

   // Snapshot of frameIn at accept, shifted down one word per SAVE beat
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift <= '0;
      end else if (w_push_ok) begin
         r_shift <= bus.frameIn;
      end else if (r_state == S_SAVE) begin
         r_shift <= {16'h0000, r_shift[FW-1:16]};
      end
   end

   // Frame memory: one write per SAVE beat, registered read during LOAD
   always_ff @(posedge clk) begin
      if (r_state == S_SAVE)
         r_mem[w_addr] <= r_shift[15:0];
      if (w_load_read)
         r_rd_data <= r_mem[w_addr];
   end

   // Restored frame: word k lands one cycle after its read is issued
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_out <= '0;
      end else if (w_load_cap) begin
         r_frame_out[{w_cap_idx, 4'b0000} +: 16] <= r_rd_data;
      end
   end

   assign bus.frameOut  = r_frame_out;
   assign bus.restore   = (r_state == S_RESTORE);
   assign bus.busy      = ~w_idle;
   assign bus.full      = w_full;
   assign bus.empty     = w_empty;
   assign bus.depth     = r_depth;
   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;
   assign bus.dbg_state = r_state;

   // The committed depth can never exceed the capacity
   assert property (@(posedge clk) disable iff (reset) r_depth <= DEPTH_MAX);

   // restore is only ever entered from a completed LOAD
   assert property (@(posedge clk) disable iff (reset)
                    (r_state == S_RESTORE) |-> $past(r_state == S_LOAD));
endmodule

// File: tb/tb_frame_stack.sv
// Self-checking bench for frame_stack: directed scenarios followed by random
// push/pop traffic. These are checked against a reference stack that is a
// plain queue of whole frames.
module tb_frame_stack;
   localparam int DEPTH = 16;
   localparam int WORDS = 15;
   localparam int FW    = 16 * WORDS;
   localparam int DW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic reset;

   frame_stack_if #(.DEPTH(DEPTH), .WORDS(WORDS)) bus ();

   frame_stack #(.DEPTH(DEPTH), .WORDS(WORDS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model and scoreboard ----------------
   logic [FW-1:0] model_q[$];   // stacked frames, back = top
   logic [FW-1:0] exp_q[$];     // frames expected on upcoming restore pulses
   logic          exp_ovf;
   logic          exp_unf;
   int            exp_pulses;
   int            seen_pulses;
   int            n_checks;
   int            n_errors;

   task automatic check(input string tag, input logic [FW-1:0] got,
                        input logic [FW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Every restore pulse must match the oldest outstanding expected frame
   always @(negedge clk) begin
      if (bus.restore === 1'b1) begin
         seen_pulses++;
         if (exp_q.size() == 0)
            check("spurious_restore", FW'(1), FW'(0));
         else
            check("frame_out", bus.frameOut, exp_q.pop_front());
      end
   end

   // ---------------- helpers ----------------
   function automatic logic [FW-1:0] rand_frame();
      logic [FW-1:0] f;
      for (int k = 0; k < WORDS; k++)
         f[16*k +: 16] = 16'($urandom);
      return f;
   endfunction

   function automatic logic [FW-1:0] ramp_frame(input logic [15:0] base);
      logic [FW-1:0] f;
      for (int k = 0; k < WORDS; k++)
         f[16*k +: 16] = base + 16'(k);
      return f;
   endfunction

   function automatic logic [FW-1:0] fill_frame(input logic [15:0] val);
      logic [FW-1:0] f;
      for (int k = 0; k < WORDS; k++)
         f[16*k +: 16] = val;
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag);
      check({tag, "_depth"}, FW'(bus.depth), FW'(model_q.size()));
      check({tag, "_full"},  FW'(bus.full),  FW'(model_q.size() == DEPTH));
      check({tag, "_empty"}, FW'(bus.empty), FW'(model_q.size() == 0));
      check({tag, "_ovf"},   FW'(bus.overflow),  FW'(exp_ovf));
      check({tag, "_unf"},   FW'(bus.underflow), FW'(exp_unf));
   endtask

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      reset    = 1'b1;
      #1;
      check("rst_frame_out", bus.frameOut, FW'(0));
      check("rst_restore",   FW'(bus.restore),   FW'(0));
      check("rst_busy",      FW'(bus.busy),      FW'(0));
      check("rst_depth",     FW'(bus.depth),     FW'(0));
      check("rst_empty",     FW'(bus.empty),     FW'(1));
      check("rst_full",      FW'(bus.full),      FW'(0));
      check("rst_ovf",       FW'(bus.overflow),  FW'(0));
      check("rst_unf",       FW'(bus.underflow), FW'(0));
      tick();
      tick();
      reset = 1'b0;
      model_q.delete();
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      tick();
   endtask

   // Push f; optionally raise pop alongside, or poke push again at E3
   task automatic do_push(input logic [FW-1:0] f, input bit with_pop,
                          input bit poke);
      int n;
      bus.push    = 1'b1;
      bus.pop     = with_pop;
      bus.frameIn = f;
      tick();
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      if (model_q.size() == DEPTH) begin
         exp_ovf = 1'b1;
         check("ovf_busy", FW'(bus.busy), FW'(0));
      end else begin
         check("save_busy", FW'(bus.busy), FW'(1));
         n = 0;
         while (bus.busy && n < 40) begin
            bus.frameIn = rand_frame();
            bus.push    = poke && (n == 2);
            if (n == 7)
               check("save_depth_mid", FW'(bus.depth), FW'(model_q.size()));
            tick();
            n++;
         end
         bus.push = 1'b0;
         check("save_len", FW'(n), FW'(15));
         model_q.push_back(f);
      end
      check_status("push");
   endtask

   task automatic do_pop();
      int n;
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
      if (model_q.size() == 0) begin
         exp_unf = 1'b1;
         check("unf_busy", FW'(bus.busy), FW'(0));
         repeat (20) tick();
      end else begin
         exp_q.push_back(model_q.pop_back());
         exp_pulses++;
         check("pop_depth_now", FW'(bus.depth), FW'(model_q.size()));
         n = 0;
         while (!bus.restore && n < 40) begin
            tick();
            n++;
         end
         check("restore_lat", FW'(n), FW'(16));
         tick();
         check("restore_width", FW'(bus.restore), FW'(0));
         check("restore_busy",  FW'(bus.busy),    FW'(0));
      end
      check_status("pop");
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int r;
      n_checks    = 0;
      n_errors    = 0;
      exp_pulses  = 0;
      seen_pulses = 0;
      exp_ovf     = 1'b0;
      exp_unf     = 1'b0;
      bus.push    = 1'b0;
      bus.pop     = 1'b0;
      bus.frameIn = '0;
      reset       = 1'b0;

      apply_reset();

      // pop on an empty stack: underflow, no restore
      do_pop();

      // single save/restore of a ramp frame
      apply_reset();
      do_push(ramp_frame(16'h1000), 1'b0, 1'b0);
      do_pop();

      // LIFO ordering
      do_push(fill_frame(16'hA0A0), 1'b0, 1'b0);
      do_push(fill_frame(16'hB0B0), 1'b0, 1'b0);
      do_push(fill_frame(16'hC0C0), 1'b0, 1'b0);
      repeat (3) do_pop();

      // simultaneous push+pop: only the push happens
      apply_reset();
      do_push(rand_frame(), 1'b1, 1'b0);
      do_pop();

      // push poked during a running save is ignored
      do_push(rand_frame(), 1'b0, 1'b1);
      do_pop();

      // fill to capacity, then overflow
      apply_reset();
      for (int i = 0; i < DEPTH; i++)
         do_push(ramp_frame(16'(i << 8)), 1'b0, 1'b0);
      do_push(rand_frame(), 1'b0, 1'b0);
      do_pop();

      // reset eight cycles into a LOAD: no restore pulse, stack empty
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
      repeat (8) tick();
      check("load_busy", FW'(bus.busy), FW'(1));
      apply_reset();
      repeat (20) tick();
      check_status("post_abort");

      // random traffic
      apply_reset();
      repeat (90) begin
         r = $urandom_range(0, 9);
         if (r < 5)
            do_push(rand_frame(), (r == 1) && (model_q.size() < DEPTH), r == 0);
         else
            do_pop();
      end
      while (model_q.size() > 0)
         do_pop();

      repeat (3) tick();
      check("pulse_count", FW'(seen_pulses), FW'(exp_pulses));
      check("exp_q_drained", FW'(exp_q.size()), FW'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1, "simulation time limit reached");
   end
endmodule
